mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single Avalon-MM port of mem_if between two masters: m0 = stim (vector/record reads), m1 = check (result read/write-back).
- Round-robin between the masters, with a per-grant burst limit so neither starves the other.
- Pipelined reads are supported. Grant changes only after all outstanding reads have returned, so readdata is always routed to the master that issued it.

Parameters:
- ADDR_WIDTH, 20, word address width.
- DATA_WIDTH, 16, data width.
- BE_WIDTH, DATA_WIDTH/8, byteenable width.
- MAX_BURST, 8, transfers accepted per grant before yielding if the other master is requesting.
- OUTST_WIDTH, 3, outstanding-read counter width; at most 2^OUTST_WIDTH-1 reads in flight.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address  in  ADDR_WIDTH  stim address.
- m0_byteenable  in  BE_WIDTH  stim byteenable.
- m0_read  in  1  stim read request.
- m0_readdata  out  DATA_WIDTH  read data to stim.
- m0_readdataready  out  1  read data valid to stim.
- m0_waitrequest  out  1  stall to stim.
- m1_address  in  ADDR_WIDTH  check address.
- m1_byteenable  in  BE_WIDTH  check byteenable.
- m1_read  in  1  check read request.
- m1_write  in  1  check write request.
- m1_writedata  in  DATA_WIDTH  check write data.
- m1_readdata  out  DATA_WIDTH  read data to check.
- m1_readdataready  out  1  read data valid to check.
- m1_waitrequest  out  1  stall to check.
- s_address  out  ADDR_WIDTH  to mem_if.
- s_byteenable  out  BE_WIDTH  to mem_if.
- s_read  out  1  to mem_if.
- s_write  out  1  to mem_if.
- s_writedata  out  DATA_WIDTH  to mem_if.
- s_readdata  in  DATA_WIDTH  from mem_if.
- s_readdataready  in  1  from mem_if.
- s_waitrequest  in  1  from mem_if.
- err_spurious  out  1  sticky: readdataready seen with zero reads outstanding.

Behaviour:
- Clock/reset: one clock, `clock`; reset is asynchronous and active-high, port `reset`.
- Reset state: state=IDLE, owner=0, rr_last=1 (so m0 wins first), outst=0, burst=0, err_spurious=0.
  - All s_* outputs 0.
  - m0/m1_waitrequest=1, readdataready=0, readdata passes s_readdata.
- Master request: reqN = mN_read | mN_write (m0_write is implicitly 0).
- States: IDLE, GRANT0, GRANT1, DRAIN. Encodings come from the package.
- IDLE:
  - Only one master requesting: grant it.
  - Both requesting: grant the one that is not rr_last.
  - Neither requesting: stay.
  - Transition is registered: the first slave request appears the cycle after the request is first seen.
- GRANTn:
  - Forward mN address, byteenable, read, write and writedata to s_* combinationally.
  - mN_waitrequest = s_waitrequest | (outst == all-ones). The other master's waitrequest = 1.
  - s_read/s_write are gated low while outst is full.
- Accept: accepted = (s_read | s_write) & ~s_waitrequest.
  - burst increments on each accept, saturating at MAX_BURST.
  - burst clears on entry to any GRANT state.
- Leave GRANTn for DRAIN when either holds:
  - ~reqN; or
  - burst == MAX_BURST and the other master is requesting.
- On leaving: rr_last <= n. Forwarding stops the same cycle the condition is seen; s_read/s_write are driven 0 in DRAIN.
- DRAIN: all masters see waitrequest=1. Go to IDLE when outst == 0, or when outst == 1 and s_readdataready is asserted this cycle.
- Outstanding counter:
  - +1 on an accepted read, -1 on s_readdataready.
  - Both in the same cycle: unchanged.
  - Writes are never counted.
- Read-data routing:
  - owner register = last granted master, unchanged in DRAIN/IDLE.
  - mX_readdataready = s_readdataready & (owner == X). readdata is shared to both masters.
- Spurious data: s_readdataready with outst == 0 sets err_spurious. outst does not underflow. err_spurious clears only on reset.
- Reset mid-transfer: everything returns to reset values immediately. Late readdataready from the slave then sets err_spurious, which is the defined behaviour.
- Latency: zero-cycle combinational path master->slave and slave readdata->master while granted; one cycle of arbitration per grant change.

Decomposition:
- Package mem_arb_pkg holds:
  - state encodings (2 bits: IDLE=00, GRANT0=01, GRANT1=10, DRAIN=11);
  - master index constants M_STIM=0, M_CHECK=1.
- One sub-module, mem_arb_outst_cnt: an up/down counter with full/empty flags and underflow detect, parameterised by OUTST_WIDTH.

Test Plan:
- Reset, then only m0_read held for 5 reads with s_waitrequest=0 -> s_read asserted from cycle 2; 5 m0_readdataready pulses; m1_readdataready never asserted.
- Both masters request continuously, MAX_BURST=8 -> grant sequence is m0 for 8 accepts, DRAIN until outst=0, then m1 for 8 accepts, then m0 again.
- m0 issues 7 back-to-back reads while readdata is delayed 10 cycles -> outst reaches 7; m0_waitrequest=1 with s_read=0 until the first data returns.
- m1 write 0xBEEF to address 0x00123 while m0 idle -> s_write=1 with s_writedata=0xBEEF; outst stays 0; no readdataready on either master.
- Inject s_readdataready with outst=0 -> err_spurious=1 next cycle and sticky; outst stays 0.
- Assert reset with 3 reads outstanding in GRANT0 -> all outputs return to reset values immediately; the 3 later readdataready pulses set err_spurious; the next m1 request is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
// State encodings are fixed so the state register can be probed on a debug bus.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10,
    ST_DRAIN  = 2'b11
  } arb_state_t;

  localparam logic M_STIM  = 1'b0;
  localparam logic M_CHECK = 1'b1;

  function automatic arb_state_t grant_state(input logic master);
    return master ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mem_arb_outst_cnt.sv
// Outstanding-read tracker: up/down counter with full/empty flags.
// A decrement while empty is reported as underflow and never wraps the count.
module mem_arb_outst_cnt #(
  parameter int OUTST_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   dec,
  output logic [OUTST_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   underflow
);

  logic dec_ok;

  assign empty     = (count == '0);
  assign full      = &count;
  assign underflow = dec & empty;
  assign dec_ok    = dec & ~empty;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({inc, dec_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined Avalon-MM slave between stim (m0) and check (m1).
// Grants only change once every outstanding read has returned, so read data needs no tagging.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_BURST   = 8,
  parameter int OUTST_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdataready,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdataready,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [BE_WIDTH-1:0]   s_byteenable,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_readdataready,
  input  logic                  s_waitrequest,
  output logic                  err_spurious
);

  localparam int                BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_t             state, next_state;
  logic                   owner, rr_last;
  logic [BURST_W-1:0]     burst;
  logic                   req0, req1, burst_done, leave;
  logic                   accepted, rd_accepted;
  logic [OUTST_WIDTH-1:0] outst;
  logic                   outst_full, outst_empty, underflow;

  assign req0       = m0_read;
  assign req1       = m1_read | m1_write;
  assign burst_done = (burst == BURST_MAX);

  assign accepted    = (s_read | s_write) & ~s_waitrequest;
  assign rd_accepted = s_read & ~s_waitrequest;

  mem_arb_outst_cnt #(.OUTST_WIDTH(OUTST_WIDTH)) u_outst (
    .clock     (clock),
    .reset     (reset),
    .inc       (rd_accepted),
    .dec       (s_readdataready),
    .count     (outst),
    .full      (outst_full),
    .empty     (outst_empty),
    .underflow (underflow)
  );

  // Yield when the owner goes quiet, or its burst is spent while the other side waits.
  always_comb begin
    leave = 1'b0;
    case (state)
      ST_GRANT0: leave = ~req0 | (burst_done & req1);
      ST_GRANT1: leave = ~req1 | (burst_done & req0);
      default:   leave = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req0 & req1)  next_state = grant_state(~rr_last);
        else if (req0)    next_state = ST_GRANT0;
        else if (req1)    next_state = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (leave) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outst_empty || (outst == OUTST_WIDTH'(1) && s_readdataready))
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (state == ST_GRANT0 && !leave) begin
      s_address      = m0_address;
      s_byteenable   = m0_byteenable;
      s_read         = m0_read & ~outst_full;
      m0_waitrequest = s_waitrequest | outst_full;
    end else if (state == ST_GRANT1 && !leave) begin
      s_address      = m1_address;
      s_byteenable   = m1_byteenable;
      s_read         = m1_read & ~outst_full;
      s_write        = m1_write & ~outst_full;
      s_writedata    = m1_writedata;
      m1_waitrequest = s_waitrequest | outst_full;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner        <= M_STIM;
      rr_last      <= M_CHECK;
      burst        <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (state == ST_IDLE && next_state != ST_IDLE) begin
        owner <= (next_state == ST_GRANT1);
        burst <= '0;
      end else if (accepted && !burst_done) begin
        burst <= burst + 1'b1;
      end
      if (leave) rr_last <= (state == ST_GRANT1);
      if (underflow) err_spurious <= 1'b1;
    end
  end

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdataready = s_readdataready & (owner == M_STIM);
  assign m1_readdataready = s_readdataready & (owner == M_CHECK);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table for arbitration/forwarding, plus a pipelined
// slave model and read-return scoreboard for the multi-cycle scenarios.
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;

  logic          clock, reset;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_read, m1_read, m1_write;
  logic [DW-1:0] m1_writedata, m0_readdata, m1_readdata, s_writedata, s_readdata;
  logic          m0_readdataready, m1_readdataready, m0_waitrequest, m1_waitrequest;
  logic          s_read, s_write, s_readdataready, s_waitrequest, err_spurious;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_readdata(m0_readdata), .m0_readdataready(m0_readdataready), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_readdataready(m1_readdataready), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .s_readdataready(s_readdataready),
    .s_waitrequest(s_waitrequest), .err_spurious(err_spurious)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } pend_t;

  typedef struct {
    logic [3:0]    in;   // {m0_read, m1_read, m1_write, s_waitrequest}
    logic [1:0]    es;   // {s_read, s_write}
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [BW-1:0] ebe;
    logic [1:0]    ew;   // {m0_waitrequest, m1_waitrequest}
  } vec_t;

  pend_t         pend[$];
  bit            ord[$];
  logic [DW-1:0] expq[$];
  bit            trace[$];
  int            cyc, lat, acc0, acc1, wr1, nret0;
  int            checks, errors;
  bit            m1_rdy_seen, inject;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5;
  endfunction

  // Observe one cycle at the negative edge: accepts feed the slave model, returns feed the scoreboard.
  task automatic monitor();
    bit who;
    logic [DW-1:0] exp_d;
    if (s_read && !s_waitrequest) begin
      check("one_grant", 32'(!m0_waitrequest) + 32'(!m1_waitrequest), 1);
      who = !m0_waitrequest ? 1'b0 : 1'b1;
      if (ord.size() > 0) check("no_mixed_outstanding", ord[$], who);
      ord.push_back(who);
      expq.push_back(rd_val(who ? m1_address : m0_address));
      pend.push_back('{rd_val(s_address), cyc + lat});
      trace.push_back(who);
      if (who) acc1++; else acc0++;
    end
    if (s_write && !s_waitrequest) wr1++;
    if (m1_readdataready) m1_rdy_seen = 1'b1;
    if (m0_readdataready) nret0++;
    if (s_readdataready && ord.size() > 0) begin
      who   = ord.pop_front();
      exp_d = expq.pop_front();
      check("rdata_route", {m1_readdataready, m0_readdataready}, who ? 2'b10 : 2'b01);
      check("rdata_value", who ? m1_readdata : m0_readdata, exp_d);
    end
  endtask

  task automatic drive_next();
    pend_t p;
    cyc++;
    m0_address      = 20'h10000 + AW'(acc0);
    m1_address      = 20'h20000 + AW'(acc1);
    s_readdataready = 1'b0;
    if (inject) begin
      s_readdataready = 1'b1;
      s_readdata      = 16'h5A5A;
      inject          = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      s_readdataready = 1'b1;
      s_readdata      = p.data;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    drive_next();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_waitrequest = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_next();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((ord.size() > 0 || pend.size() > 0) && n < 200) begin
      cycle();
      n++;
    end
    check(name, ord.size(), 0);
    repeat (3) cycle();
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, stalls;
    bit done;
    checks = 0; errors = 0; cyc = 0; lat = 1;
    acc0 = 0; acc1 = 0; wr1 = 0; nret0 = 0; m1_rdy_seen = 0; inject = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = 2'b01; m1_byteenable = 2'b11;
    m0_read = 0; m1_read = 0; m1_write = 0; m1_writedata = '0;
    s_readdata = 16'h1234; s_readdataready = 0; s_waitrequest = 0;
    reset = 1'b0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst_s_rw", {s_read, s_write}, 2'b00);
    check("rst_s_addr", s_address, 0);
    check("rst_s_wdata", s_writedata, 0);
    check("rst_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("rst_rdy", {m0_readdataready, m1_readdataready}, 2'b00);
    check("rst_err", err_spurious, 0);
    check("rst_rdata_pass", m0_readdata, 16'h1234);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: five m0 reads, first slave read the cycle after the request is seen
    lat = 1;
    m0_read = 1'b1;
    m0_address = 20'h10000;
    @(negedge clock); monitor();
    check("t1_idle_cycle_s_read", s_read, 0);
    @(posedge clock); #1; drive_next();
    @(negedge clock); monitor();
    check("t1_cycle2_s_read", s_read, 1);
    @(posedge clock); #1; drive_next();
    n = 0;
    while (acc0 < 5 && n < 50) begin cycle(); n++; end
    check("t1_accepts", acc0, 5);
    m0_read = 1'b0;
    drain("t1_drain");
    check("t1_m0_returns", nret0, 5);
    check("t1_m1_rdy_never", m1_rdy_seen, 0);

    // Vector table: arbitration walk, forwarding and the m1 BEEF write
    do_reset();
    vecs[0]  = '{4'b0000, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[1]  = '{4'b0010, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[2]  = '{4'b0010, 2'b01, 20'h00123, 16'hBEEF, 2'b11, 2'b10};
    vecs[3]  = '{4'b0011, 2'b01, 20'h00123, 16'hBEEF, 2'b11, 2'b11};
    vecs[4]  = '{4'b1000, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[5]  = '{4'b1000, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[6]  = '{4'b1001, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[7]  = '{4'b1001, 2'b10, 20'h0ABCD, 16'h0,    2'b01, 2'b11};
    vecs[8]  = '{4'b0001, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[9]  = '{4'b0000, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[10] = '{4'b0101, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[11] = '{4'b0101, 2'b10, 20'h00123, 16'hBEEF, 2'b11, 2'b11};
    vecs[12] = '{4'b0000, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    vecs[13] = '{4'b0000, 2'b00, 20'h0,     16'h0,    2'b00, 2'b11};
    m0_address = 20'h0ABCD; m1_address = 20'h00123; m1_writedata = 16'hBEEF;
    for (int i = 0; i < 14; i++) begin
      {m0_read, m1_read, m1_write, s_waitrequest} = vecs[i].in;
      @(negedge clock);
      check($sformatf("vec%0d_s_rw", i), {s_read, s_write}, vecs[i].es);
      check($sformatf("vec%0d_s_addr", i), s_address, vecs[i].ea);
      check($sformatf("vec%0d_s_wdata", i), s_writedata, vecs[i].ewd);
      check($sformatf("vec%0d_s_be", i), s_byteenable, vecs[i].ebe);
      check($sformatf("vec%0d_waits", i), {m0_waitrequest, m1_waitrequest}, vecs[i].ew);
      check($sformatf("vec%0d_rdy", i), {m0_readdataready, m1_readdataready}, 2'b00);
      @(posedge clock);
      #1;
    end
    {m0_read, m1_read, m1_write, s_waitrequest} = 4'b0000;

    // 2: both masters request continuously; bursts of eight alternate
    do_reset();
    acc0 = 0; acc1 = 0; trace.delete(); lat = 2;
    m0_read = 1'b1; m1_read = 1'b1;
    n = 0;
    while (trace.size() < 24 && n < 300) begin cycle(); n++; end
    check("t2_accepts", trace.size(), 24);
    m0_read = 1'b0; m1_read = 1'b0;
    drain("t2_drain");
    for (int i = 0; i < 24 && i < trace.size(); i++)
      check($sformatf("t2_grant_seq%0d", i), trace[i], (i >= 8 && i < 16) ? 1 : 0);

    // 3: seven reads in flight with slow data; the eighth stalls until data returns
    do_reset();
    acc0 = 0; lat = 10;
    m0_read = 1'b1;
    n = 0;
    while (acc0 < 7 && n < 30) begin cycle(); n++; end
    check("t3_accepts", acc0, 7);
    stalls = 0; done = 0; n = 0;
    while (!done && n < 30) begin
      @(negedge clock);
      monitor();
      if (s_readdataready) done = 1;
      else begin
        check("t3_s_read_gated", s_read, 0);
        check("t3_m0_wait", m0_waitrequest, 1);
        stalls++;
      end
      @(posedge clock); #1; drive_next();
      n++;
    end
    check("t3_stall_cycles", stalls, 3);
    m0_read = 1'b0;
    drain("t3_drain");

    // 5: spurious readdataready sets a sticky error and leaves the counter at zero
    check("t5_err_before", err_spurious, 0);
    inject = 1'b1;
    cycle();
    @(negedge clock); monitor();
    check("t5_err_not_yet", err_spurious, 0);
    @(posedge clock); #1; drive_next();
    @(negedge clock); monitor();
    check("t5_err_set", err_spurious, 1);
    @(posedge clock); #1; drive_next();
    repeat (4) cycle();
    check("t5_err_sticky", err_spurious, 1);
    wr1 = 0; m1_writedata = 16'h0F0F; m1_write = 1'b1;
    n = 0;
    while (wr1 < 1 && n < 10) begin cycle(); n++; end
    check("t5_write_after_spurious", wr1, 1);
    m1_write = 1'b0;
    repeat (3) cycle();

    // 6: reset with three reads in flight; late data flags the error, arbitration recovers
    acc0 = 0; acc1 = 0; lat = 10;
    m0_read = 1'b1;
    n = 0;
    while (acc0 < 3 && n < 20) begin cycle(); n++; end
    check("t6_accepts", acc0, 3);
    reset = 1'b1; m0_read = 1'b0;
    #1;
    check("t6_rst_s_rw", {s_read, s_write}, 2'b00);
    check("t6_rst_s_addr", s_address, 0);
    check("t6_rst_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("t6_rst_err", err_spurious, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive_next();
    drain("t6_late_drain");
    check("t6_err_late", err_spurious, 1);
    m1_read = 1'b1;
    n = 0;
    while (acc1 < 1 && n < 10) begin cycle(); n++; end
    check("t6_m1_granted", acc1, 1);
    m1_read = 1'b0;
    drain("t6_m1_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
